// File: rtl/ddp_seg_hdr_gen_if.sv
// Command and record channels of the DDP segment header generator.
// Handshake: a transfer happens on a rising clock edge where valid and ready are both high; the sender holds payload stable until then.
interface ddp_seg_hdr_gen_if #(
  parameter int TID_W     = 8,
  parameter int SEG_MAX   = 4,
  parameter int SEG_LEN_W = 9,
  parameter int QN_W      = 4,
  parameter int HDR_W     = 56
);
  localparam int CNT_W = $clog2(SEG_MAX + 1);
  localparam int DDP_W = CNT_W + QN_W + SEG_LEN_W;

  logic                      cmdValid;
  logic                      cmdReady;
  logic [3:0]                cmdOpcode;
  logic [TID_W-1:0]          cmdTid;
  logic [CNT_W-1:0]          cmdSegNum;
  logic [SEG_MAX*SEG_LEN_W-1:0] cmdLenVec;
  logic [SEG_MAX*QN_W-1:0]   cmdQnVec;
  logic [HDR_W-1:0]          cmdRdmapHdr;
  logic [7:0]                cmdRdmapCtrl;

  logic                      outValid;
  logic                      outReady;
  logic [HDR_W-1:0]          outRdmapHdr;
  logic [7:0]                outRdmapCtrl;
  logic [DDP_W-1:0]          outDdpHdr;
  logic [1:0]                outDdpCtrl;

  modport master (
    output cmdValid, cmdOpcode, cmdTid, cmdSegNum, cmdLenVec, cmdQnVec, cmdRdmapHdr, cmdRdmapCtrl,
    input  cmdReady,
    input  outValid, outRdmapHdr, outRdmapCtrl, outDdpHdr, outDdpCtrl,
    output outReady
  );

  modport slave (
    input  cmdValid, cmdOpcode, cmdTid, cmdSegNum, cmdLenVec, cmdQnVec, cmdRdmapHdr, cmdRdmapCtrl,
    output cmdReady,
    output outValid, outRdmapHdr, outRdmapCtrl, outDdpHdr, outDdpCtrl,
    input  outReady
  );
endinterface

// File: rtl/ddp_seg_hdr_gen.sv
// DDP header generator: REQ stores a per-TID segmentation plan, SEND replays it as one
// DDP header record per segment, REQ/ACK each emit one fixed record.
module ddp_seg_hdr_gen #(
  parameter int TID_W     = 8,
  parameter int SEG_MAX   = 4,
  parameter int SEG_LEN_W = 9,
  parameter int QN_W      = 4,
  parameter int HDR_W     = 56
) (
  input  logic                          clock,
  input  logic                          reset,
  ddp_seg_hdr_gen_if.slave              bus,
  input  logic                          procRd,
  input  logic [TID_W-1:0]              procRdAddr,
  output logic [$clog2(SEG_MAX+1)-1:0]  procRdData,
  output logic                          procRdValid,
  output logic                          cmdErr,
  output logic [1:0]                    dbgState
);
  localparam int CNT_W  = $clog2(SEG_MAX + 1);
  localparam int DEPTH  = 2 ** TID_W;
  localparam int LENV_W = SEG_MAX * SEG_LEN_W;
  localparam int QNV_W  = SEG_MAX * QN_W;
  localparam logic [3:0] OP_SEND = 4'b0000;
  localparam logic [3:0] OP_REQ  = 4'b0011;
  localparam logic [3:0] OP_ACK  = 4'b0111;
  localparam logic [CNT_W-1:0] SEG_MAX_C = CNT_W'(SEG_MAX);

  typedef enum logic [1:0] {IDLE, RD_TBL, LOAD, EMIT} state_t;
  state_t state, stateNext;

  logic [DEPTH-1:0]  entryValid;
  logic [CNT_W-1:0]  segTbl [DEPTH];
  logic [LENV_W-1:0] lenTbl [DEPTH];
  logic [QNV_W-1:0]  qnTbl  [DEPTH];

  logic [TID_W-1:0]     tidReg;
  logic                 sendOk;
  logic [CNT_W-1:0]     sendSeg;
  logic [LENV_W-1:0]    sendLen;
  logic [QNV_W-1:0]     sendQn;
  logic [CNT_W-1:0]     curCnt, segIdx;
  logic                 unkErr;
  logic                 accept, isReq, isAck, isSend;
  logic                 loadFixed, loadSeg, clearOut;
  logic [CNT_W-1:0]     selIdx, selCnt, segW;
  logic [SEG_LEN_W-1:0] selLen;
  logic [QN_W-1:0]      selQn;

  assign bus.cmdReady = (state == IDLE) && !bus.outValid;
  assign accept       = bus.cmdValid && bus.cmdReady;
  assign isReq        = (bus.cmdOpcode == OP_REQ);
  assign isAck        = (bus.cmdOpcode == OP_ACK);
  assign isSend       = (bus.cmdOpcode == OP_SEND);
  assign segW         = (bus.cmdSegNum > SEG_MAX_C) ? SEG_MAX_C : bus.cmdSegNum;
  assign cmdErr       = unkErr || ((state == LOAD) && !sendOk);
  assign dbgState     = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              entryValid <= '0;
    else if (accept && isReq) entryValid[bus.cmdTid] <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (accept && isReq) begin
      segTbl[bus.cmdTid] <= segW;
      lenTbl[bus.cmdTid] <= bus.cmdLenVec;
      qnTbl[bus.cmdTid]  <= bus.cmdQnVec;
    end
  end

  // Single read port: the SEND lookup owns it during RD_TBL, the side port otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sendOk      <= 1'b0;
      sendSeg     <= '0;
      sendLen     <= '0;
      sendQn      <= '0;
      procRdValid <= 1'b0;
      procRdData  <= '0;
    end else begin
      if (state == RD_TBL) begin
        sendOk  <= entryValid[tidReg] && (segTbl[tidReg] != '0);
        sendSeg <= segTbl[tidReg];
        sendLen <= lenTbl[tidReg];
        sendQn  <= qnTbl[tidReg];
      end
      procRdValid <= procRd && (state != RD_TBL);
      procRdData  <= (procRd && (state != RD_TBL) && entryValid[procRdAddr]) ? segTbl[procRdAddr] : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadFixed = 1'b0;
    loadSeg   = 1'b0;
    clearOut  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (isReq || isAck) begin
            loadFixed = 1'b1;
            stateNext = EMIT;
          end else if (isSend) begin
            stateNext = RD_TBL;
          end
        end
      end
      RD_TBL: stateNext = LOAD;
      LOAD: begin
        if (sendOk) begin
          loadSeg   = 1'b1;
          stateNext = EMIT;
        end else begin
          stateNext = IDLE;
        end
      end
      EMIT: begin
        if (bus.outValid && bus.outReady) begin
          if (segIdx == curCnt) begin
            clearOut  = 1'b1;
            stateNext = IDLE;
          end else begin
            loadSeg = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // LOAD always produces segment 0; EMIT produces the segment after the one just accepted.
  assign selIdx = (state == LOAD) ? '0 : segIdx;
  assign selCnt = (state == LOAD) ? sendSeg : curCnt;

  always_comb begin
    selLen = '0;
    selQn  = '0;
    for (int i = 0; i < SEG_MAX; i++) begin
      if (selIdx == CNT_W'(i)) begin
        selLen = sendLen[i*SEG_LEN_W +: SEG_LEN_W];
        selQn  = sendQn[(SEG_MAX-1-i)*QN_W +: QN_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.outValid     <= 1'b0;
      bus.outRdmapHdr  <= '0;
      bus.outRdmapCtrl <= '0;
      bus.outDdpHdr    <= '0;
      bus.outDdpCtrl   <= '0;
      curCnt           <= '0;
      segIdx           <= '0;
      tidReg           <= '0;
      unkErr           <= 1'b0;
    end else begin
      unkErr <= accept && !isReq && !isAck && !isSend;
      if (accept) begin
        tidReg           <= bus.cmdTid;
        bus.outRdmapHdr  <= bus.cmdRdmapHdr;
        bus.outRdmapCtrl <= bus.cmdRdmapCtrl;
      end
      if (loadFixed) begin
        bus.outValid   <= 1'b1;
        bus.outDdpHdr  <= {CNT_W'(0), QN_W'(0), (isAck ? SEG_LEN_W'(4) : SEG_LEN_W'(6))};
        bus.outDdpCtrl <= 2'b11;
        curCnt         <= CNT_W'(1);
        segIdx         <= CNT_W'(1);
      end else if (loadSeg) begin
        bus.outValid   <= 1'b1;
        bus.outDdpHdr  <= {selIdx, selQn, selLen + SEG_LEN_W'(1)};
        bus.outDdpCtrl <= {(selIdx == '0), ((selIdx + CNT_W'(1)) == selCnt)};
        curCnt         <= selCnt;
        segIdx         <= selIdx + CNT_W'(1);
      end else if (clearOut) begin
        bus.outValid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/ddp_seg_hdr_gen.md
Name: ddp_seg_hdr_gen

Overview:
Parametrised DDP header generator that sits between the RDMAP header generator and the packet encapsulation stage.
- A REQ command records a segmentation plan for a transaction ID (TID): segment count, per-segment lengths and per-segment queue numbers.
- A later SEND to that TID emits one DDP header record per segment.
- REQ and ACK each emit a single fixed DDP header record.
- Records leave through a registered valid/ready output; a side port lets another block read the stored segment count.

Parameters:
TID_W, 8, TID width; table depth is 2**TID_W.
SEG_MAX, 4, maximum segments per message (range 1..7).
SEG_LEN_W, 9, per-segment length field width.
QN_W, 4, per-segment queue number width.
HDR_W, 56, RDMAP header width.
(local) CNT_W = clog2(SEG_MAX+1).
(local) DDP_W = CNT_W + QN_W + SEG_LEN_W.

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
cmdValid  in  1  command present
cmdReady  out  1  command accepted when cmdValid&cmdReady
cmdOpcode  in  4  0000 SEND, 0011 REQ, 0111 ACK
cmdTid  in  TID_W  transaction ID
cmdSegNum  in  CNT_W  REQ only: segment count
cmdLenVec  in  SEG_MAX*SEG_LEN_W  REQ only: field i holds (length-1) of segment i
cmdQnVec  in  SEG_MAX*QN_W  REQ only: field (SEG_MAX-1-i) holds the queue number of segment i
cmdRdmapHdr  in  HDR_W  RDMAP header passed through
cmdRdmapCtrl  in  8  RDMAP ctrl passed through
outValid  out  1  record valid
outReady  in  1  downstream accepts the record
outRdmapHdr  out  HDR_W  header of the owning command
outRdmapCtrl  out  8  ctrl of the owning command
outDdpHdr  out  DDP_W  {PID, QN, LEN}
outDdpCtrl  out  2  {sop, eop}
procRd  in  1  side read request
procRdAddr  in  TID_W  side read TID
procRdData  out  CNT_W  stored segment count (0 if entry unwritten)
procRdValid  out  1  procRdData valid this cycle
cmdErr  out  1  one-cycle pulse when a command is dropped

Behaviour:
Reset values:
- All outputs 0 except cmdReady, which is 1.
- FSM returns to IDLE.
- All table entry valid bits cleared.
- Reset asserted mid-message abandons the message with no further records.

FSM states: IDLE, RD_TBL, LOAD, EMIT.
- cmdReady = (state == IDLE) and the output register is empty.
- REQ accepted at cycle T:
  - Table write [cmdTid] = {segNum, lenVec, qnVec}; valid bit set.
  - Record loaded and outValid = 1 at T+1.
  - Record content: DDP header {PID 0, QN 0, LEN 6}, ctrl {1,1}.
  - State EMIT.
- ACK accepted at T: as REQ but LEN = 4 and no table write.
- SEND accepted at T:
  - T+1: state RD_TBL; synchronous table read at cmdTid, which was registered at accept.
  - T+2: state LOAD; read data captured.
  - Segment 0 record visible with outValid = 1 at T+3.
- SEND to an unwritten entry, or to an entry with segNum = 0: no record is emitted; cmdErr pulses in LOAD; return to IDLE.
- segNum > SEG_MAX is clamped to SEG_MAX at the REQ write.
- Unknown opcode: accepted, dropped, cmdErr pulses at T+1, state stays IDLE.
- Segment i record:
  - PID = i.
  - QN = qnVec field (SEG_MAX-1-i).
  - LEN = lenVec field i + 1, computed modulo 2**SEG_LEN_W (all-ones field wraps to 0).
  - sop = (i == 0); eop = (i == segNum-1). A 1-segment message has sop = eop = 1.
- Output register:
  - Holds its content stable while outValid & ~outReady.
  - On outValid & outReady at cycle t, the next segment is loaded at t+1, giving back-to-back records.
  - After the last record is accepted: outValid = 0 at t+1, state IDLE, cmdReady = 1.
- outRdmapHdr/outRdmapCtrl equal the values captured at accept for every record of that command.
- Side port:
  - procRd at t gives procRdData/procRdValid at t+1.
  - In the RD_TBL cycle the SEND read has priority: a procRd in that cycle yields procRdValid = 0, and the requester must retry.
- Same-cycle table write and side read of the same TID return the old data.

Test Plan:
1. REQ tid=5, segNum=3, len fields {0x0FF, 0x010, 0x000}, qn {A,B,C,x}; outReady=1 -> one record LEN 6, ctrl {1,1}. Then SEND tid=5 -> records PID 0/1/2, LEN 0x100/0x011/0x001, QN A/B/C, ctrl 10/00/01, consecutive cycles.
2. SEND tid=5 with outReady held low 4 cycles on segment 1 -> segment 1 held stable, no loss or duplication; segment 2 follows one cycle after outReady rises.
3. ACK -> single record LEN 4, ctrl 11; SEND to unwritten tid=9 -> no outValid, one cmdErr pulse, cmdReady back high.
4. REQ segNum=1, len field 0x1FF -> SEND emits one record, ctrl 11, LEN 0 (wrap); REQ segNum=7 with SEG_MAX=4 -> SEND emits exactly 4 records.
5. procRd tid=5 colliding with the RD_TBL cycle -> procRdValid=0; retry next cycle -> procRdData=3, procRdValid=1.
6. Assert reset during segment 1 of a 4-segment SEND -> outValid=0 immediately; after release, SEND tid=5 gives cmdErr because valid bits were cleared.
